seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 120 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 8-digit seven-segment scanner with a double-buffered digit store.
// New digits are written to a shadow buffer and copied to the displayed buffer only on a frame wrap.
module seg_scan_ctrl #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 8
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       en,
    input  logic       lzb,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       wr_dp,
    input  logic       commit,
    output logic       commit_pend,
    output logic       frame_done,
    output logic [7:0] digit,
    output logic [7:0] seg_data
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PCNT_MAX  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYC);

    // Each entry is {value[3:0], dp}
    logic [4:0]    shadow [8];
    logic [4:0]    active [8];
    logic [PW-1:0] pcnt;
    logic [2:0]    idx;

    logic       slot_end;
    logic       boundary;
    logic       do_copy;
    logic [4:0] cur;
    logic       prefix_blank;
    logic       zero_blank;
    logic [7:0] digit_nxt;
    logic [7:0] seg_nxt;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'd0:    glyph = 7'h7E;
            4'd1:    glyph = 7'h30;
            4'd2:    glyph = 7'h6D;
            4'd3:    glyph = 7'h79;
            4'd4:    glyph = 7'h33;
            4'd5:    glyph = 7'h5B;
            4'd6:    glyph = 7'h5F;
            4'd7:    glyph = 7'h70;
            4'd8:    glyph = 7'h7F;
            4'd9:    glyph = 7'h7B;
            default: glyph = 7'h00;
        endcase
    endfunction

    assign slot_end = (pcnt == PCNT_MAX);
    assign boundary = slot_end && (idx == 3'd7);
    // A commit arriving in the boundary cycle itself is honoured at that boundary
    assign do_copy  = boundary && (commit_pend || commit);

    always_comb begin
        cur          = active[idx];
        prefix_blank = 1'b1;
        for (int j = 0; j < 7; j++) begin
            if ((3'(j) < idx) && (active[j][4:1] != 4'd0) && (active[j][4:1] < 4'd10)) begin
                prefix_blank = 1'b0;
            end
        end
        zero_blank = lzb && (idx != 3'd7) && (cur[4:1] == 4'd0) && prefix_blank;

        digit_nxt = (!en || (pcnt < BLANK_END)) ? 8'h00 : (8'h80 >> idx);
        if (digit_nxt == 8'h00) begin
            seg_nxt = 8'h00;
        end else if (zero_blank) begin
            seg_nxt = {7'b0, cur[0]};
        end else begin
            seg_nxt = {glyph(cur[4:1]), cur[0]};
        end
    end

    // Copy reads the pre-edge shadow, so a same-cycle write only lands in shadow
    always_ff @(posedge clk) begin
        if (!rstb) begin
            pcnt        <= '0;
            idx         <= 3'd0;
            commit_pend <= 1'b0;
            frame_done  <= 1'b0;
            digit       <= 8'h00;
            seg_data    <= 8'h00;
            for (int k = 0; k < 8; k++) begin
                shadow[k] <= 5'b1111_0;
                active[k] <= 5'b1111_0;
            end
        end else begin
            pcnt       <= slot_end ? '0 : pcnt + 1'b1;
            idx        <= slot_end ? idx + 3'd1 : idx;
            frame_done <= boundary;
            digit      <= digit_nxt;
            seg_data   <= seg_nxt;

            if (boundary) begin
                commit_pend <= 1'b0;
            end else if (commit) begin
                commit_pend <= 1'b1;
            end

            if (do_copy) begin
                for (int k = 0; k < 8; k++) begin
                    active[k] <= shadow[k];
                end
            end

            if (wr_en) begin
                shadow[wr_addr] <= {wr_data, wr_dp};
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized and directed bench for seg_scan_ctrl, compared every cycle against
// a frame-time reference model (slot/position derived from elapsed cycles).
module tb_seg_scan_ctrl;

    localparam int SCAN_DIV  = 4;
    localparam int BLANK_CYC = 1;
    localparam int FRAME     = SCAN_DIV * 8;

    logic       clk = 1'b0;
    logic       rstb;
    logic       en;
    logic       lzb;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_dp;
    logic       commit;
    logic       commit_pend;
    logic       frame_done;
    logic [7:0] digit;
    logic [7:0] seg_data;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) dut (
        .clk(clk), .rstb(rstb), .en(en), .lzb(lzb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_dp(wr_dp),
        .commit(commit), .commit_pend(commit_pend), .frame_done(frame_done),
        .digit(digit), .seg_data(seg_data)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: elapsed cycles since reset, buffers as plain arrays
    int  t;
    int  sv [8];
    int  sd [8];
    int  av [8];
    int  ad [8];
    bit  pend;
    logic [7:0] exp_digit;
    logic [7:0] exp_seg;
    logic       exp_fd;
    logic [7:0] glyph_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                   8'hFE, 8'hF6, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %02h expected %02h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [7:0] model_seg(input int pos);
        bit lead = 1'b1;
        for (int j = 0; j < pos; j++) begin
            if (av[j] != 0 && av[j] < 10) lead = 1'b0;
        end
        if (lzb && pos < 7 && av[pos] == 0 && lead) return {7'b0, 1'(ad[pos])};
        return glyph_tab[av[pos]] | {7'b0, 1'(ad[pos])};
    endfunction

    task automatic model_reset();
        t    = 0;
        pend = 1'b0;
        for (int k = 0; k < 8; k++) begin
            sv[k] = 15; sd[k] = 0; av[k] = 15; ad[k] = 0;
        end
        exp_digit = 8'h00;
        exp_seg   = 8'h00;
        exp_fd    = 1'b0;
    endtask

    // One clock edge: advance the model with the inputs present at the edge, then check
    task automatic applyStimulus();
        int  p;
        int  i;
        bit  bnd;
        @(posedge clk);
        if (!rstb) begin
            model_reset();
        end else begin
            p   = t % SCAN_DIV;
            i   = (t / SCAN_DIV) % 8;
            bnd = (p == SCAN_DIV - 1) && (i == 7);
            exp_digit = (!en || p < BLANK_CYC) ? 8'h00 : (8'h80 >> i);
            exp_seg   = (exp_digit == 8'h00) ? 8'h00 : model_seg(i);
            exp_fd    = bnd;
            if (bnd && (pend || commit)) begin
                for (int k = 0; k < 8; k++) begin
                    av[k] = sv[k]; ad[k] = sd[k];
                end
            end
            if (bnd) pend = 1'b0;
            else if (commit) pend = 1'b1;
            if (wr_en) begin
                sv[wr_addr] = int'(wr_data);
                sd[wr_addr] = int'(wr_dp);
            end
            t++;
        end
        #1;
        checkOutput("digit", digit, exp_digit);
        checkOutput("seg_data", seg_data, exp_seg);
        checkOutput("frame_done", {7'b0, frame_done}, {7'b0, exp_fd});
        checkOutput("commit_pend", {7'b0, commit_pend}, {7'b0, pend});
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) applyStimulus();
    endtask

    task automatic write_digit(input int a, input int v, input bit dp);
        wr_en = 1'b1; wr_addr = 3'(a); wr_data = 4'(v); wr_dp = dp;
        applyStimulus();
        wr_en = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        applyStimulus();
        commit = 1'b0;
    endtask

    initial begin
        rstb = 1'b0; en = 1'b1; lzb = 1'b0; wr_en = 1'b0;
        wr_addr = 3'd0; wr_data = 4'd0; wr_dp = 1'b0; commit = 1'b0;
        model_reset();
        run(2);
        rstb = 1'b1;

        // Blank display scan after reset
        run(40);

        // Positions 0..7 = 1..8, one commit, then two frames
        for (int a = 0; a < 8; a++) write_digit(a, a + 1, a[0]);
        do_commit();
        run(2 * FRAME + 5);

        // Shadow write without commit stays invisible, then commit
        write_digit(3, 5, 1'b0);
        run(3 * FRAME);
        do_commit();
        run(FRAME + 8);

        // Commit plus write to position 0 in the boundary cycle
        for (int k = 0; k < FRAME && (t % FRAME) != FRAME - 1; k++) applyStimulus();
        commit = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'd9; wr_dp = 1'b0;
        applyStimulus();
        commit = 1'b0; wr_en = 1'b0;
        run(FRAME + 4);
        do_commit();
        run(FRAME + 4);

        // Leading-zero pattern 0,0,0,0,1,2,0,0
        for (int a = 0; a < 8; a++) write_digit(a, (a == 4) ? 1 : (a == 5) ? 2 : 0, 1'b0);
        write_digit(1, 0, 1'b1);
        do_commit();
        lzb = 1'b1;
        run(2 * FRAME);
        lzb = 1'b0;
        run(FRAME);

        // Reset mid-frame with a pending commit and a colliding write
        do_commit();
        run(5);
        rstb = 1'b0; commit = 1'b1; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'd3;
        applyStimulus();
        rstb = 1'b1; commit = 1'b0; wr_en = 1'b0;
        run(FRAME + 3);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            en      = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) lzb = ~lzb;
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            wr_dp   = ($urandom_range(0, 3) == 0);
            commit  = ($urandom_range(0, 19) == 0);
            rstb    = ($urandom_range(0, 299) != 0);
            applyStimulus();
        end
        rstb = 1'b1; wr_en = 1'b0; commit = 1'b0;
        run(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
